alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer_if.sv | 35 +++
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the control path and alu_op_sequencer.
//   master: control-path side; drives the request and resp_ready.
//   slave : sequencer side; drives req_ready and the response fields.
// Signals:
//   req_valid/req_ready    request handshake
//   req_op, req_a, req_b   opcode and operands
//   resp_valid/resp_ready  response handshake
//   resp_result, resp_zero captured ALU result and Zero flag
//   resp_taken             branch taken (BEQ/BNE only)
//   resp_error             illegal opcode
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_taken;
  logic             resp_error;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_taken, resp_error
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_taken, resp_error
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: accepts a request, drives the ALU
// operands and ALUControl, waits out the ALU's one-cycle registered latency,
// then presents result, Zero and branch-taken status as a response.
// Ports:
//   clock, reset_n         clock (rising edge) and asynchronous active-low reset
//   bus                    request/response bundle (slave side)
//   alu_input1/alu_input2  registered operands to the ALU
//   alu_control            registered ALUControl to the ALU
//   alu_result, alu_zero   ALU outputs, sampled only in CAPTURE
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  alu_op_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]    alu_input1,
  output logic [WIDTH-1:0]    alu_input2,
  output logic [2:0]          alu_control,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StResp    = 2'd3;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpSlt = 3'b100;
  localparam logic [2:0] OpBeq = 3'b101;
  localparam logic [2:0] OpBne = 3'b110;
  localparam logic [2:0] OpIll = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [2:0]       ctl_q, ctl_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             taken_q, taken_d;
  logic             error_q, error_d;
  logic             req_ready;
  logic [2:0]       ctl_dec;

  // Gated by reset_n so the request side sees "not ready" while held in reset.
  assign req_ready = reset_n && (state_q == StIdle);

  always_comb begin
    ctl_dec = 3'b000;
    unique case (bus.req_op)
      OpAnd:   ctl_dec = 3'b000;
      OpOr:    ctl_dec = 3'b001;
      OpAdd:   ctl_dec = 3'b010;
      OpSub:   ctl_dec = 3'b110;
      OpSlt:   ctl_dec = 3'b111;
      OpBeq:   ctl_dec = 3'b110;
      OpBne:   ctl_dec = 3'b110;
      default: ctl_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    ctl_d        = ctl_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    zero_d       = zero_q;
    taken_d      = taken_q;
    error_d      = error_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready) begin
          op_d = bus.req_op;
          if (bus.req_op == OpIll) begin
            // Answer directly without touching the ALU-facing registers.
            result_d     = '0;
            zero_d       = 1'b0;
            taken_d      = 1'b0;
            error_d      = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else begin
            in1_d   = bus.req_a;
            in2_d   = bus.req_b;
            ctl_d   = ctl_dec;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        result_d     = alu_result;
        zero_d       = alu_zero;
        error_d      = 1'b0;
        resp_valid_d = 1'b1;
        taken_d      = (op_q == OpBeq) ? alu_zero :
                       (op_q == OpBne) ? ~alu_zero : 1'b0;
        state_d      = StResp;
      end
      StResp: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      op_q         <= 3'b000;
      in1_q        <= '0;
      in2_q        <= '0;
      ctl_q        <= 3'b000;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      taken_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      ctl_q        <= ctl_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      taken_q      <= taken_d;
      error_q      <= error_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_taken  = taken_q;
  assign bus.resp_error  = error_q;
  assign alu_input1      = in1_q;
  assign alu_input2      = in2_q;
  assign alu_control     = ctl_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int unsigned W = 16;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] alu_input1, alu_input2, alu_result;
  logic [2:0]   alu_control;
  logic         alu_zero;

  int checks = 0;
  int failures = 0;

  // Expected ALU-facing register contents (only legal accepts update them).
  logic [2:0]   m_ctl;
  logic [W-1:0] m_a, m_b;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_control(alu_control),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clock = ~clock;

  // Registered ALU: one-cycle latency, ALUControl encoding.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? W'(1) : W'(0);
      default: return W'(16'hDEAD);
    endcase
  endfunction

  always @(posedge clock) begin
    alu_result <= alu_fn(alu_control, alu_input1, alu_input2);
    alu_zero   <= (alu_fn(alu_control, alu_input1, alu_input2) == '0);
  end

  // Reference: what the request opcode means arithmetically.
  function automatic logic [2:0] ref_ctl(input logic [2:0] op);
    case (op)
      3'd0: return 3'b000;
      3'd1: return 3'b001;
      3'd2: return 3'b010;
      3'd4: return 3'b111;
      default: return 3'b110;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd4: return (a < b) ? W'(1) : W'(0);
      3'd7: return '0;
      default: return a - b;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_resp(input string tag, input logic [W-1:0] r, input logic z,
                            input logic t, input logic e);
    check_eq({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(bus.resp_result), 32'(r));
    check_eq({tag, "_zero"}, 32'(bus.resp_zero), 32'(z));
    check_eq({tag, "_taken"}, 32'(bus.resp_taken), 32'(t));
    check_eq({tag, "_error"}, 32'(bus.resp_error), 32'(e));
    check_eq({tag, "_rdy_busy"}, 32'(bus.req_ready), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W-1:0] er;
    logic         ez, et, ee;
    er = ref_result(op, a, b);
    ee = (op == 3'd7);
    ez = !ee && (er == '0);
    et = (op == 3'd5) ? (a == b) : (op == 3'd6) ? (a != b) : 1'b0;

    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clock);
    // Busy-time request traffic must be ignored.
    bus.req_valid = 1'($urandom);
    bus.req_op    = 3'($urandom);
    bus.req_a     = W'($urandom);
    bus.req_b     = W'($urandom);
    if (ee) begin
      check_resp("ill", er, ez, et, ee);
      check_eq("ill_ctl_kept", 32'(alu_control), 32'(m_ctl));
      check_eq("ill_in1_kept", 32'(alu_input1), 32'(m_a));
      check_eq("ill_in2_kept", 32'(alu_input2), 32'(m_b));
    end else begin
      m_ctl = ref_ctl(op);
      m_a   = a;
      m_b   = b;
      check_eq("issue_ctl", 32'(alu_control), 32'(m_ctl));
      check_eq("issue_in1", 32'(alu_input1), 32'(m_a));
      check_eq("issue_in2", 32'(alu_input2), 32'(m_b));
      check_eq("issue_valid", 32'(bus.resp_valid), 32'd0);
      check_eq("issue_rdy", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
      check_eq("capture_valid", 32'(bus.resp_valid), 32'd0);
      bus.req_valid = 1'($urandom);
      @(negedge clock);
      check_resp("resp", er, ez, et, ee);
    end
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'($urandom);
      @(negedge clock);
      check_resp("stall", er, ez, et, ee);
      check_eq("stall_ctl", 32'(alu_control), 32'(m_ctl));
    end
    bus.req_valid  = 1'($urandom);
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check_eq("done_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("done_rdy", 32'(bus.req_ready), 32'd1);
    check_eq("done_result_kept", 32'(bus.resp_result), 32'(er));
  endtask

  initial begin
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'd2;
    bus.req_a      = 16'h1111;
    bus.req_b      = 16'h2222;
    bus.resp_ready = 1'b0;
    m_ctl = 3'b000;
    m_a   = '0;
    m_b   = '0;

    // Reset held with a request pending.
    repeat (3) @(negedge clock);
    check_eq("rst_rdy", 32'(bus.req_ready), 32'd0);
    check_eq("rst_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_in1", 32'(alu_input1), 32'd0);
    check_eq("rst_in2", 32'(alu_input2), 32'd0);
    check_eq("rst_ctl", 32'(alu_control), 32'd0);
    check_eq("rst_fields", {28'd0, bus.resp_zero, bus.resp_taken, bus.resp_error, 1'b0}, 32'd0);
    check_eq("rst_result", 32'(bus.resp_result), 32'd0);
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("post_rst_rdy", 32'(bus.req_ready), 32'd1);
    check_eq("post_rst_valid", 32'(bus.resp_valid), 32'd0);

    // Directed cases.
    run_op(3'd2, 16'h1234, 16'h0001, 0);
    run_op(3'd5, 16'h00FF, 16'h00FF, 0);
    run_op(3'd6, 16'h00FF, 16'h00FF, 0);
    run_op(3'd6, 16'h0005, 16'h0003, 1);
    run_op(3'd4, 16'h0003, 16'h0007, 0);
    run_op(3'd4, 16'h0007, 16'h0003, 0);
    run_op(3'd0, 16'hF0F0, 16'h0FF0, 0);
    run_op(3'd1, 16'hF0F0, 16'h0FF0, 0);
    run_op(3'd3, 16'h0010, 16'h0001, 5);
    run_op(3'd7, 16'hAAAA, 16'h5555, 2);
    run_op(3'd4, 16'hFFFF, 16'h0001, 0);

    // Reset during CAPTURE: operation must vanish.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd2;
    bus.req_a     = 16'h0100;
    bus.req_b     = 16'h0200;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("midrst_rdy", 32'(bus.req_ready), 32'd0);
    check_eq("midrst_ctl", 32'(alu_control), 32'd0);
    check_eq("midrst_in1", 32'(alu_input1), 32'd0);
    m_ctl = 3'b000;
    m_a   = '0;
    m_b   = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
      check_eq("midrst_idle", 32'(bus.req_ready), 32'd1);
    end
    run_op(3'd2, 16'h0002, 16'h0002, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
